// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, bubble instruction and
// the bit positions inside the stall_and_flush control vector.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DONE = 2'd2
    } fetch_state_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    localparam int STALL_BIT = 0;
    localparam int FLUSH_BIT = 1;

endpackage

// File: rtl/if_fetch_if.sv
// Wishbone classic read bus between the fetch stage (master) and memory (slave).
// Handshake: a request is pending while wb_cyc_o & wb_stb_o are high with wb_adr_o
// stable; it completes on the rising edge where wb_ack_i is high, wb_dat_i valid then.
interface if_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                      wb_cyc_o;
    logic                      wb_stb_o;
    logic                      wb_we_o;
    logic [ADDR_WIDTH-1:0]     wb_adr_o;
    logic [DATA_WIDTH/8-1:0]   wb_sel_o;
    logic                      wb_ack_i;
    logic [DATA_WIDTH-1:0]     wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o,
        output wb_ack_i, wb_dat_i
    );

endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: one Wishbone read per instruction, all outputs
// registered, flushes during an open cycle drop the returning data.
module if_fetch
    import pipeline_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INST   = NOP_INST_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [1:0]            stall_and_flush,
    if_fetch_if.master            wb,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  inst_valid,
    output logic                  fetch_misaligned,
    output logic                  fetch_busy,
    output fetch_state_e          fetch_state
);

    fetch_state_e          state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  valid_q, valid_d;
    logic                  mis_q, mis_d;
    logic                  discard_q, discard_d;

    logic stall;
    logic flush;

    assign stall = stall_and_flush[STALL_BIT];
    assign flush = stall_and_flush[FLUSH_BIT];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= FETCH_IDLE;
            cyc_q     <= 1'b0;
            adr_q     <= '0;
            pc_q      <= '0;
            inst_q    <= NOP_INST;
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            adr_q     <= adr_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            valid_q   <= valid_d;
            mis_q     <= mis_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        adr_d     = adr_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        valid_d   = valid_q;
        mis_d     = mis_q;
        discard_d = discard_q;

        case (state_q)
            FETCH_IDLE, FETCH_DONE: begin
                // Flush wins over stall; a stalled DONE simply parks its result.
                if (flush) begin
                    state_d = FETCH_IDLE;
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    mis_d   = 1'b0;
                end else if (!stall) begin
                    pc_d = pc_in;
                    if (pc_in[1:0] != 2'b00) begin
                        state_d = FETCH_DONE;
                        inst_d  = NOP_INST;
                        valid_d = 1'b1;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = FETCH_WAIT;
                        cyc_d   = 1'b1;
                        adr_d   = pc_in;
                        inst_d  = NOP_INST;
                        valid_d = 1'b0;
                        mis_d   = 1'b0;
                    end
                end
            end
            FETCH_WAIT: begin
                // The bus cycle is never aborted; a flush only marks its data for dropping.
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (wb.wb_ack_i) begin
                    cyc_d = 1'b0;
                    mis_d = 1'b0;
                    if (discard_q || flush) begin
                        state_d   = FETCH_IDLE;
                        inst_d    = NOP_INST;
                        valid_d   = 1'b0;
                        discard_d = 1'b0;
                    end else begin
                        state_d = FETCH_DONE;
                        inst_d  = wb.wb_dat_i;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = FETCH_IDLE;
                cyc_d     = 1'b0;
                valid_d   = 1'b0;
                discard_d = 1'b0;
            end
        endcase
    end

    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_we_o  = 1'b0;
    assign wb.wb_sel_o = '1;
    assign wb.wb_adr_o = adr_q;

    assign inst_out         = inst_q;
    assign pc_out           = pc_q;
    assign inst_valid       = valid_q;
    assign fetch_misaligned = mis_q;
    assign fetch_busy       = (state_q == FETCH_WAIT);
    assign fetch_state      = state_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: stimulus pushes expected fetch results into a
// queue, a negedge monitor pops and compares each new result the stage presents.
module tb_if_fetch;
    import pipeline_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  pc_in;
    logic [1:0]   sf;
    logic [31:0]  inst_out;
    logic [31:0]  pc_out;
    logic         inst_valid;
    logic         fetch_misaligned;
    logic         fetch_busy;
    fetch_state_e fetch_state;

    int n_vec  = 0;
    int n_miss = 0;

    logic [64:0] exp_q[$];
    logic [64:0] exp_item;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc    = '0;
    logic [31:0] prev_inst  = '0;

    if_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

    if_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NOP_INST(NOP)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_in            (pc_in),
        .stall_and_flush  (sf),
        .wb               (wb),
        .inst_out         (inst_out),
        .pc_out           (pc_out),
        .inst_valid       (inst_valid),
        .fetch_misaligned (fetch_misaligned),
        .fetch_busy       (fetch_busy),
        .fetch_state      (fetch_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic void chk(string name, logic [64:0] act, logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endfunction

    // monitor: every new result on the IF/ID outputs must match the queue head
    always @(negedge clk) begin
        if (reset && inst_valid &&
            (!prev_valid || pc_out !== prev_pc || inst_out !== prev_inst)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_result: got pc %0h inst %0h required no result",
                         pc_out, inst_out);
            end else begin
                exp_item = exp_q.pop_front();
                chk("result", {fetch_misaligned, pc_out, inst_out}, exp_item);
            end
        end
        prev_valid = inst_valid;
        prev_pc    = pc_out;
        prev_inst  = inst_out;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_cyc"},   65'(wb.wb_cyc_o), 65'(0));
        chk({tag, "_stb"},   65'(wb.wb_stb_o), 65'(0));
        chk({tag, "_adr"},   65'(wb.wb_adr_o), 65'(0));
        chk({tag, "_pc"},    65'(pc_out), 65'(0));
        chk({tag, "_inst"},  65'(inst_out), 65'(NOP));
        chk({tag, "_valid"}, 65'(inst_valid), 65'(0));
        chk({tag, "_mis"},   65'(fetch_misaligned), 65'(0));
        chk({tag, "_busy"},  65'(fetch_busy), 65'(0));
        chk({tag, "_state"}, 65'(fetch_state), 65'(FETCH_IDLE));
    endtask

    // Launch an aligned fetch, ack after `waits` wait states, park in DONE under stall.
    task automatic fetch(input logic [31:0] pc, input int waits, input logic [31:0] dat);
        int busy_cycles;
        busy_cycles = 0;
        pc_in = pc;
        sf    = 2'b00;
        exp_q.push_back({1'b0, pc, dat});
        step();
        for (int k = 0; k <= waits; k++) begin
            settle();
            chk("cyc_stb_in_wait", 65'(wb.wb_cyc_o & wb.wb_stb_o), 65'(1));
            chk("adr_stable", 65'(wb.wb_adr_o), 65'(pc));
            if (fetch_busy) busy_cycles++;
            if (k == waits) begin
                wb.wb_ack_i = 1'b1;
                wb.wb_dat_i = dat;
                sf          = 2'b01;
            end
            step();
        end
        wb.wb_ack_i = 1'b0;
        settle();
        chk("busy_cycles", 65'(busy_cycles), 65'(waits + 1));
        chk("busy_after_ack", 65'(fetch_busy), 65'(0));
        chk("cyc_after_ack", 65'(wb.wb_cyc_o), 65'(0));
        chk("valid_after_ack", 65'(inst_valid), 65'(1));
    endtask

    task automatic fetch_misaligned_pc(input logic [31:0] pc);
        pc_in = pc;
        sf    = 2'b00;
        exp_q.push_back({1'b1, pc, NOP});
        step();
        sf = 2'b01;
        settle();
        chk("mis_no_cyc", 65'(wb.wb_cyc_o), 65'(0));
        chk("mis_flag", 65'(fetch_misaligned), 65'(1));
        chk("mis_inst", 65'(inst_out), 65'(NOP));
        chk("mis_busy", 65'(fetch_busy), 65'(0));
    endtask

    initial begin
        reset       = 1'b0;
        sf          = 2'b01;
        pc_in       = 32'h0;
        wb.wb_ack_i = 1'b0;
        wb.wb_dat_i = 32'h0;
        step();
        step();
        settle();
        check_reset_values("reset");
        chk("reset_we", 65'(wb.wb_we_o), 65'(0));
        chk("reset_sel", 65'(wb.wb_sel_o), 65'(4'hf));
        reset = 1'b1;
        step();
        settle();
        chk("idle_stalled", 65'(fetch_state), 65'(FETCH_IDLE));

        fetch(32'h8000_0000, 0, 32'h0010_0093);
        fetch(32'h8000_0004, 3, 32'h0020_0113);
        fetch_misaligned_pc(32'h8000_0002);

        // Parked under stall with spurious acks: nothing may move.
        for (int i = 0; i < 5; i++) begin
            wb.wb_ack_i = 1'b1;
            wb.wb_dat_i = 32'hdead_beef;
            step();
            settle();
            chk("stall_pc", 65'(pc_out), 65'(32'h8000_0002));
            chk("stall_inst", 65'(inst_out), 65'(NOP));
            chk("stall_valid", 65'(inst_valid), 65'(1));
            chk("stall_no_cyc", 65'(wb.wb_cyc_o), 65'(0));
        end
        wb.wb_ack_i = 1'b0;
        fetch(32'h8000_000c, 1, 32'h0030_0193);

        sf = 2'b11;
        step();
        sf = 2'b01;
        settle();
        chk("flush_done_state", 65'(fetch_state), 65'(FETCH_IDLE));
        chk("flush_done_valid", 65'(inst_valid), 65'(0));
        chk("flush_done_inst", 65'(inst_out), 65'(NOP));
        chk("flush_done_mis", 65'(fetch_misaligned), 65'(0));

        // Flush while waiting, ack arrives two cycles later.
        pc_in = 32'h8000_0008;
        sf    = 2'b00;
        step();
        sf = 2'b10;
        step();
        settle();
        chk("flush_wait_no_abort", 65'(wb.wb_cyc_o), 65'(1));
        sf = 2'b00;
        step();
        wb.wb_ack_i = 1'b1;
        wb.wb_dat_i = 32'h0040_0213;
        sf          = 2'b01;
        step();
        wb.wb_ack_i = 1'b0;
        settle();
        chk("flush_wait_state", 65'(fetch_state), 65'(FETCH_IDLE));
        chk("flush_wait_valid", 65'(inst_valid), 65'(0));
        chk("flush_wait_cyc", 65'(wb.wb_cyc_o), 65'(0));
        fetch(32'h8000_0100, 0, 32'h0050_0293);

        // Flush in the same cycle as the ack.
        pc_in = 32'h8000_0110;
        sf    = 2'b00;
        step();
        settle();
        chk("flush_ack_cyc", 65'(wb.wb_cyc_o), 65'(1));
        wb.wb_ack_i = 1'b1;
        wb.wb_dat_i = 32'h0060_0313;
        sf          = 2'b10;
        step();
        wb.wb_ack_i = 1'b0;
        sf          = 2'b01;
        settle();
        chk("flush_ack_state", 65'(fetch_state), 65'(FETCH_IDLE));
        chk("flush_ack_valid", 65'(inst_valid), 65'(0));
        chk("flush_ack_inst", 65'(inst_out), 65'(NOP));

        // Reset pulse mid-WAIT, then a late ack.
        pc_in = 32'h8000_0200;
        sf    = 2'b00;
        step();
        settle();
        chk("rst_wait_cyc", 65'(wb.wb_cyc_o), 65'(1));
        reset = 1'b0;
        step();
        reset       = 1'b1;
        sf          = 2'b01;
        wb.wb_ack_i = 1'b1;
        wb.wb_dat_i = 32'h0070_0393;
        settle();
        check_reset_values("rst_wait");
        step();
        wb.wb_ack_i = 1'b0;
        settle();
        chk("late_ack_state", 65'(fetch_state), 65'(FETCH_IDLE));
        chk("late_ack_valid", 65'(inst_valid), 65'(0));
        chk("late_ack_cyc", 65'(wb.wb_cyc_o), 65'(0));

        fetch(32'h8000_0204, 2, 32'h0080_0413);
        step();
        settle();
        chk("queue_empty", 65'(exp_q.size()), 65'(0));

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
